// File: rtl/cv32e40p_x_resp_fifo.sv
// Coprocessor response FIFO: buffers X-interface results toward the core with
// first-word-fall-through head, registered handshakes and a sticky error flag.
module cv32e40p_x_resp_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FILL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              x_p_valid_i,
  output logic              x_p_ready_o,
  input  logic [4:0]        x_p_rd_i,
  input  logic [31:0]       x_p_data_i,
  input  logic              x_p_dualwb_i,
  input  logic              x_p_type_i,
  input  logic              x_p_error_i,
  output logic              x_rvalid_o,
  input  logic              x_rready_i,
  output logic [4:0]        x_rd_o,
  output logic [31:0]       x_data_o,
  output logic              x_dualwb_o,
  output logic              x_type_o,
  output logic              x_error_o,
  output logic [FILL_W-1:0] fill_o,
  output logic              error_seen_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = 5 + 32 + 3;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [FILL_W-1:0]  fill_q;
  logic               error_seen_q;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Handshakes depend only on registered occupancy, never on the peer's inputs.
  assign x_p_ready_o = (fill_q < FILL_W'(DEPTH));
  assign x_rvalid_o  = (fill_q != '0);

  assign push = x_p_valid_i && x_p_ready_o && !flush_i;
  assign pop  = x_rvalid_o && x_rready_i && !flush_i;

  assign wr_entry = {x_p_rd_i, x_p_data_i, x_p_dualwb_i, x_p_type_i, x_p_error_i};

  // Head payload is masked to zero while empty so stale storage never leaks out.
  assign head_entry = x_rvalid_o ? mem[rd_ptr_q] : '0;
  assign {x_rd_o, x_data_o, x_dualwb_o, x_type_o, x_error_o} = head_entry;

  assign fill_o       = fill_q;
  assign error_seen_o = error_seen_q;

  // Storage array: written on push only, deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointers, occupancy and sticky error; flush overrides push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      error_seen_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      error_seen_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        fill_q <= fill_q + FILL_W'(1);
      end else if (pop && !push) begin
        fill_q <= fill_q - FILL_W'(1);
      end
      if (push && x_p_error_i) begin
        error_seen_q <= 1'b1;
      end
    end
  end

endmodule
